bcd_countdown_timer: RTL and testbench

- Countdown counterpart of the team's BCD stopwatch: a three-digit BCD timer (XX.X s, 0.1 s resolution) that loads a preset and counts down to 00.0.
- Reports expiry with a one-cycle pulse and a sticky level.
- Sits beside the stopwatch and feeds the same seven-segment display mux through d2/d1/d0.

---
 rtl/bcd_timer_pkg.sv | 19 +
 rtl/bcd_down_digit.sv | 33 +++
 rtl/bcd_countdown_timer.sv | 140 ++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encoding, digit limits
// and preset saturation.
package bcd_timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam bcd_t BCD_MAX = 4'd9;

  // Out-of-range preset nibbles clamp to 9 so the digits never hold a non-BCD code.
  function automatic bcd_t bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain: loadable, clearable, decrements 0 -> 9
// with a borrow out to the next more significant digit.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       dec_en,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= 4'd0;
    end else if (clr) begin
      r_q <= 4'd0;
    end else if (ld) begin
      r_q <= ld_val;
    end else if (dec_en) begin
      r_q <= (r_q == 4'd0) ? BCD_MAX : (r_q - 4'd1);
    end
  end

  assign q      = r_q;
  assign borrow = dec_en && (r_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown timer (XX.X s): preset load, start/stop/clear
// control, 0.1 s prescaler and expiry reporting.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DVSR = 10_000_000,
  parameter int PW   = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] p2,
  input  logic [3:0] p1,
  input  logic [3:0] p0,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       busy,
  output logic       expired,
  output logic       done_tick
);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DVSR - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [PW-1:0] r_presc;
  logic          r_done_tick;

  logic [3:0] w_q2, w_q1, w_q0;
  logic       w_b0, w_b1, w_b2;
  logic       w_in_run, w_tick, w_ld, w_stop, w_go, w_dec, w_expire;
  logic       w_zero, w_one;

  assign w_in_run = (r_state == ST_RUN);
  assign w_zero   = (w_q2 == 4'd0) && (w_q1 == 4'd0) && (w_q0 == 4'd0);
  assign w_one    = (w_q2 == 4'd0) && (w_q1 == 4'd0) && (w_q0 == 4'd1);
  assign w_tick   = w_in_run && (r_presc == PRESC_LAST);

  // Priority clr > load > stop > start; load is inert while running.
  assign w_ld     = !clr && load && !w_in_run;
  assign w_stop   = !clr && stop && w_in_run;
  assign w_go     = !clr && !load && !stop && start &&
                    (((r_state == ST_IDLE) && !w_zero) || (r_state == ST_PAUSE));
  assign w_dec    = w_tick && !clr && !stop;
  assign w_expire = w_dec && w_one;

  always_comb begin
    w_state_nxt = r_state;
    if (clr || w_ld) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_go)     w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (w_stop)        w_state_nxt = ST_PAUSE;
          else if (w_expire) w_state_nxt = ST_DONE;
        end
        ST_PAUSE: if (w_go)     w_state_nxt = ST_RUN;
        default:                w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A stop held in the tick cycle freezes the prescaler at its last value, so
  // the tick fires on the first cycle after resuming.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (clr || w_ld) begin
      r_presc <= '0;
    end else if (w_in_run && !stop) begin
      r_presc <= w_tick ? '0 : (r_presc + PW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done_tick <= 1'b0;
    end else begin
      r_done_tick <= w_expire;
    end
  end

  bcd_down_digit u_d0 (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .ld     (w_ld),
    .ld_val (bcd_sat(p0)),
    .dec_en (w_dec),
    .q      (w_q0),
    .borrow (w_b0)
  );

  bcd_down_digit u_d1 (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .ld     (w_ld),
    .ld_val (bcd_sat(p1)),
    .dec_en (w_b0),
    .q      (w_q1),
    .borrow (w_b1)
  );

  // The top digit's borrow would mean wrapping below 000, which expiry prevents.
  bcd_down_digit u_d2 (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .ld     (w_ld),
    .ld_val (bcd_sat(p2)),
    .dec_en (w_b1),
    .q      (w_q2),
    .borrow (w_b2)
  );

  assign d2        = w_q2;
  assign d1        = w_q1;
  assign d0        = w_q0;
  assign busy      = w_in_run;
  assign expired   = (r_state == ST_DONE);
  assign done_tick = r_done_tick;

  logic w_unused;
  assign w_unused = w_b2;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with DVSR = 4: expected output
// words are queued with the stimulus and compared when the DUT responds.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load, start, stop, clr;
  logic [3:0] p2, p1, p0;
  logic [3:0] d2, d1, d0;
  logic       busy, expired, done_tick;

  logic [14:0] exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  bcd_countdown_timer #(.DVSR(4), .PW(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .p2       (p2),
    .p1       (p1),
    .p0       (p0),
    .start    (start),
    .stop     (stop),
    .clr      (clr),
    .d2       (d2),
    .d1       (d1),
    .d0       (d0),
    .busy     (busy),
    .expired  (expired),
    .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  // Output word: {busy, expired, done_tick, d2, d1, d0}
  function automatic logic [14:0] mk(input logic b, input logic e, input logic t,
                                     input logic [3:0] x2, input logic [3:0] x1,
                                     input logic [3:0] x0);
    return {b, e, t, x2, x1, x0};
  endfunction

  task automatic check_out(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got busy/exp/tick=%b digits=%h, want busy/exp/tick=%b digits=%h",
               tag, obs[14:12], obs[11:0], exp[14:12], exp[11:0]);
    end
  endtask

  task automatic expect_out(input string tag, input logic [14:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_out();
    logic [14:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_out(t, {busy, expired, done_tick, d2, d1, d0}, e);
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] x2, input logic [3:0] x1, input logic [3:0] x0);
    p2 = x2; p1 = x1; p0 = x0; load = 1'b1;
    cycle(1);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle(1);
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cycle(1);
    clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    p2 = 4'd0; p1 = 4'd0; p0 = 4'd0;
    expect_out("reset", mk(0, 0, 0, 0, 0, 0));
    #12;
    compare_out();
    #11 reset_n = 1'b1;
    cycle(1);

    // Basic countdown 012 -> 009 with a d1 borrow.
    expect_out("load_012", mk(0, 0, 0, 0, 1, 2));
    do_load(4'd0, 4'd1, 4'd2);
    compare_out();
    expect_out("busy_after_start", mk(1, 0, 0, 0, 1, 2));
    pulse_start();
    compare_out();
    expect_out("pre_first_tick", mk(1, 0, 0, 0, 1, 2));
    cycle(3);
    compare_out();
    expect_out("tick1_011", mk(1, 0, 0, 0, 1, 1));
    cycle(1);
    compare_out();
    expect_out("tick2_010", mk(1, 0, 0, 0, 1, 0));
    cycle(4);
    compare_out();
    expect_out("tick3_borrow_009", mk(1, 0, 0, 0, 0, 9));
    cycle(4);
    compare_out();
    expect_out("clr_run", mk(0, 0, 0, 0, 0, 0));
    pulse_clr();
    compare_out();

    // Expiry from 001, then DONE ignores start for 20 cycles.
    do_load(4'd0, 4'd0, 4'd1);
    pulse_start();
    expect_out("run_001", mk(1, 0, 0, 0, 0, 1));
    cycle(3);
    compare_out();
    expect_out("expire_pulse", mk(0, 1, 1, 0, 0, 0));
    cycle(1);
    compare_out();
    expect_out("done_tick_fall", mk(0, 1, 0, 0, 0, 0));
    cycle(1);
    compare_out();
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expect_out("done_hold", mk(0, 1, 0, 0, 0, 0));
      cycle(1);
      compare_out();
    end
    start = 1'b0;

    // Double borrow 100 -> 099 (load also leaves DONE).
    expect_out("load_100_from_done", mk(0, 0, 0, 1, 0, 0));
    do_load(4'd1, 4'd0, 4'd0);
    compare_out();
    pulse_start();
    expect_out("double_borrow_099", mk(1, 0, 0, 0, 9, 9));
    cycle(4);
    compare_out();
    expect_out("load_in_run_ignored", mk(1, 0, 0, 0, 9, 9));
    do_load(4'd5, 4'd5, 4'd5);
    compare_out();
    pulse_clr();

    // Preset saturation.
    expect_out("load_sat", mk(0, 0, 0, 9, 3, 9));
    do_load(4'hF, 4'd3, 4'hC);
    compare_out();

    // Pause and resume: prescaler held, tick after 2 more RUN cycles.
    pulse_start();
    expect_out("run6_938", mk(1, 0, 0, 9, 3, 8));
    cycle(6);
    compare_out();
    stop = 1'b1;
    cycle(1);
    stop = 1'b0;
    expect_out("pause_frozen", mk(0, 0, 0, 9, 3, 8));
    cycle(10);
    compare_out();
    expect_out("resume_busy", mk(1, 0, 0, 9, 3, 8));
    pulse_start();
    compare_out();
    expect_out("resume_one_cycle", mk(1, 0, 0, 9, 3, 8));
    cycle(1);
    compare_out();
    expect_out("resume_tick_937", mk(1, 0, 0, 9, 3, 7));
    cycle(1);
    compare_out();

    // stop coinciding with a tick: no decrement, tick on first RUN cycle after resume.
    cycle(3);
    stop = 1'b1;
    expect_out("stop_beats_tick", mk(0, 0, 0, 9, 3, 7));
    cycle(1);
    stop = 1'b0;
    compare_out();
    pulse_start();
    expect_out("tick_on_resume_936", mk(1, 0, 0, 9, 3, 6));
    cycle(1);
    compare_out();
    pulse_clr();

    // clr during the done_tick cycle.
    do_load(4'd0, 4'd0, 4'd1);
    pulse_start();
    cycle(4);
    expect_out("clr_in_done_tick", mk(0, 0, 0, 0, 0, 0));
    pulse_clr();
    compare_out();

    // Priority: start at 000 ignored, clr beats load.
    expect_out("start_at_zero", mk(0, 0, 0, 0, 0, 0));
    pulse_start();
    compare_out();
    expect_out("clr_beats_load", mk(0, 0, 0, 0, 0, 0));
    clr = 1'b1;
    do_load(4'd7, 4'd7, 4'd7);
    clr = 1'b0;
    compare_out();

    // Asynchronous reset in the middle of RUN, between clock edges.
    do_load(4'd5, 4'd5, 4'd5);
    pulse_start();
    expect_out("pre_reset_run", mk(1, 0, 0, 5, 5, 5));
    cycle(2);
    compare_out();
    expect_out("async_reset", mk(0, 0, 0, 0, 0, 0));
    #2 reset_n = 1'b0;
    #1;
    compare_out();
    expect_out("reset_held", mk(0, 0, 0, 0, 0, 0));
    cycle(1);
    compare_out();
    reset_n = 1'b1;
    cycle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
